// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer between the host command decoder and the CPU core.
// Optional watchdog is built only when RUN_CTRL_WDT_EN is defined.
module cpu_run_ctrl #(
  parameter int unsigned STEP_CYCLES = 1,
  parameter logic [23:0] WDT_CYCLES  = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_run,
  input  logic        cmd_resume,
  input  logic        cmd_step,
  input  logic        cmd_halt,
  input  logic [31:2] cmd_start_adr,
  input  logic        bp_en,
  input  logic [31:2] bp_adr,
  input  logic [31:0] pc_data,
  output logic        cpu_start,
  output logic [31:2] start_adr,
  output logic        quit_cmd,
  output logic        halted,
  output logic [31:2] halt_pc,
  output logic [2:0]  stop_cause,
  output logic        bp_hit
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOP
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_HOST = 3'd1,
    CAUSE_STEP = 3'd2,
    CAUSE_BP   = 3'd3,
    CAUSE_WDT  = 3'd4
  } cause_t;

  localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

  state_t      state_q, state_d;
  cause_t      stop_cause_q, stop_cause_d;
  cause_t      run_cause;
  logic [7:0]  run_cnt_q, run_cnt_d;
  logic        step_q, step_d;
  logic        cpu_start_q, cpu_start_d;
  logic        quit_cmd_q, quit_cmd_d;
  logic        bp_hit_q, bp_hit_d;
  logic        halted_q, halted_d;
  logic [31:2] start_adr_q, start_adr_d;
  logic [31:2] halt_pc_q, halt_pc_d;
  logic        wdt_expire;
  logic        cfg_unused;

  assign cfg_unused = ^{pc_data[1:0], WDT_CYCLES};

`ifdef RUN_CTRL_WDT_EN
  localparam logic [23:0] WDT_LAST = WDT_CYCLES - 24'd1;

  logic [23:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d = wdt_q;
    if (state_q == S_START) begin
      wdt_d = '0;
    end else if (state_q == S_RUN) begin
      wdt_d = wdt_q + 24'd1;
    end
  end

  assign wdt_expire = (state_q == S_RUN) && (wdt_q == WDT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  assign wdt_expire = 1'b0;
`endif

  // Stop conditions checked while running, highest priority first.
  always_comb begin
    run_cause = CAUSE_NONE;
    if (cmd_halt) begin
      run_cause = CAUSE_HOST;
    end else if (bp_en && (pc_data[31:2] == bp_adr) && (run_cnt_q != 8'd0)) begin
      run_cause = CAUSE_BP;
    end else if (wdt_expire) begin
      run_cause = CAUSE_WDT;
    end else if (step_q && (run_cnt_q == STEP_LAST)) begin
      run_cause = CAUSE_STEP;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    step_d       = step_q;
    start_adr_d  = start_adr_q;
    halt_pc_d    = halt_pc_q;
    stop_cause_d = stop_cause_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_step || cmd_resume) begin
          start_adr_d  = halt_pc_q;
          step_d       = cmd_step;
          stop_cause_d = CAUSE_NONE;
          state_d      = S_START;
        end else if (cmd_run) begin
          start_adr_d  = cmd_start_adr;
          step_d       = 1'b0;
          stop_cause_d = CAUSE_NONE;
          state_d      = S_START;
        end
      end
      S_START: begin
        run_cnt_d = '0;
        if (cmd_halt) begin
          stop_cause_d = CAUSE_HOST;
          state_d      = S_STOP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (run_cnt_q != 8'hFF) begin
          run_cnt_d = run_cnt_q + 8'd1;
        end
        if (run_cause != CAUSE_NONE) begin
          stop_cause_d = run_cause;
          state_d      = S_STOP;
        end
      end
      S_STOP: begin
        halt_pc_d = pc_data[31:2];
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    cpu_start_d = (state_d == S_START);
    quit_cmd_d  = (state_d == S_STOP);
    bp_hit_d    = (state_d == S_STOP) && (stop_cause_d == CAUSE_BP);
    halted_d    = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      run_cnt_q    <= '0;
      step_q       <= 1'b0;
      start_adr_q  <= '0;
      halt_pc_q    <= '0;
      stop_cause_q <= CAUSE_NONE;
      cpu_start_q  <= 1'b0;
      quit_cmd_q   <= 1'b0;
      bp_hit_q     <= 1'b0;
      halted_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      step_q       <= step_d;
      start_adr_q  <= start_adr_d;
      halt_pc_q    <= halt_pc_d;
      stop_cause_q <= stop_cause_d;
      cpu_start_q  <= cpu_start_d;
      quit_cmd_q   <= quit_cmd_d;
      bp_hit_q     <= bp_hit_d;
      halted_q     <= halted_d;
    end
  end

  assign cpu_start  = cpu_start_q;
  assign start_adr  = start_adr_q;
  assign quit_cmd   = quit_cmd_q;
  assign halted     = halted_q;
  assign halt_pc    = halt_pc_q;
  assign stop_cause = stop_cause_q;
  assign bp_hit     = bp_hit_q;

endmodule
